fetch_stage: RTL

- Instruction-fetch stage of the in-order pipeline; owns the architectural PC and sequences requests to the instruction memory port over a valid/ready handshake.
- Buffers one returned instruction and presents it with its PC and PC+4 to the IF/ID pipeline register.
- Applies control-flow redirects from execute, discarding wrong-path responses that are still in flight.
- Drives a NOP bubble whenever no valid instruction is available.

---
 rtl/fetch_stage.sv | 63 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the PC, one-outstanding imem requests, redirects and IF/ID output
// Ports: clk/reset (async, active-high); imem_req_valid/ready/addr request channel;
// imem_resp_valid/data response channel; redirect_valid/pc from execute; stall from IF/ID;
// f_valid/f_instr/f_pc/f_pc4 to the IF/ID register (f_instr is NOP_INSTR when f_valid=0).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic [31:0] f_pc4
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ibuf, ibuf_n, rpc;
  assign rpc = {redirect_pc[31:2], 2'b00};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      ibuf  <= NOP_INSTR;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ibuf  <= ibuf_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = redirect_valid ? rpc : pc;
    ibuf_n  = ibuf;
    case (state)
      // a redirect while the request is being accepted leaves a wrong-path response to drop
      S_REQ:  state_n = imem_req_ready ? (redirect_valid ? S_DROP : S_WAIT) : S_REQ;
      S_WAIT: begin
        state_n = redirect_valid ? (imem_resp_valid ? S_REQ : S_DROP) : (imem_resp_valid ? S_HOLD : S_WAIT);
        ibuf_n  = (!redirect_valid && imem_resp_valid) ? imem_resp_data : ibuf;
      end
      S_DROP: state_n = imem_resp_valid ? S_REQ : S_DROP;
      default: begin
        state_n = (redirect_valid || !stall) ? S_REQ : S_HOLD;
        pc_n    = redirect_valid ? rpc : (stall ? pc : pc + 32'd4);
        ibuf_n  = redirect_valid ? NOP_INSTR : ibuf;
      end
    endcase
  end
  assign imem_req_valid = (state == S_REQ) && !reset;
  assign imem_req_addr  = pc;
  assign f_valid        = (state == S_HOLD) && !redirect_valid;
  assign f_instr        = f_valid ? ibuf : NOP_INSTR;
  assign f_pc           = pc;
  assign f_pc4          = pc + 32'd4;
endmodule
